// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks PCs from the branch controller, issues memory reads, registers words for decode.
// Latency: a word acked in cycle N is presented on instr from cycle N+1; a zero-wait memory sustains one word per cycle.
// Backpressure: stall holds instr/instr_valid; no new request while the slot is full, and a word acked mid-stall lands in a 1-entry skid.
//
// Ports:
//   clk, reset_n              rising-edge clock, asynchronous active-low reset
//   start, halt_req           leave IDLE/HALT / stop after any in-flight access (halt wins over start)
//   stall                     downstream cannot take instr this cycle
//   pc_bout, nop_en           next PC and squash request from the branch controller
//   imem_req/addr/ack/rdata   instruction memory read port (addr always equals pc)
//   pc                        current fetch PC, fed back to the branch controller
//   instr, instr_valid        registered instruction towards decode
//   busy                      registered: sequencer is in FETCH or WAIT
//   squash_cnt, fetch_cnt     saturating squash count, wrapping delivered-word count
module fetch_seq #(
    parameter int                 DATA_W   = 16,
    parameter logic [DATA_W-1:0]  RESET_PC = 16'h0000,
    parameter logic [DATA_W-1:0]  NOP_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              stall,
    input  logic [DATA_W-1:0] pc_bout,
    input  logic              nop_en,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              busy,
    output logic [7:0]        squash_cnt,
    output logic [15:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;

    logic              slot_free;
    logic              skid_move;
    logic              capture;
    logic [DATA_W-1:0] capture_word;

    // Slot is free when nothing is presented or the presented word leaves this cycle.
    assign slot_free    = !instr_valid || !stall;
    // The skid drains into instr independently of state so a halt cannot strand it.
    assign skid_move    = skid_vld && slot_free;
    assign capture_word = nop_en ? NOP_WORD : imem_rdata;
    assign imem_addr    = pc;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !halt_req) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (slot_free && !skid_vld) begin
                    // A parked skid word must reach instr before the next read goes out.
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The access is already committed, so halt only takes effect once the ack arrives.
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = halt_req ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (start && !halt_req) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_FETCH) || (state_nxt == S_WAIT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (capture) begin
            pc <= pc_bout;
        end else if (state == S_IDLE && state_nxt == S_FETCH) begin
            pc <= RESET_PC;
        end
    end

    // Output slot plus skid. A direct capture and a skid drain never coincide:
    // FETCH only requests with an empty skid, and the skid fills only on the way out of WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            skid_vld    <= 1'b0;
            skid_dat    <= NOP_WORD;
        end else begin
            if (capture && slot_free) begin
                instr       <= capture_word;
                instr_valid <= 1'b1;
            end else if (skid_move) begin
                instr       <= skid_dat;
                instr_valid <= 1'b1;
                skid_vld    <= 1'b0;
            end else if (instr_valid && !stall) begin
                instr_valid <= 1'b0;
            end
            if (capture && !slot_free) begin
                skid_vld <= 1'b1;
                skid_dat <= capture_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            squash_cnt <= 8'h00;
            fetch_cnt  <= 16'h0000;
        end else begin
            if (capture && nop_en && squash_cnt != 8'hFF) begin
                squash_cnt <= squash_cnt + 8'h01;
            end
            if (instr_valid && !stall) begin
                fetch_cnt <= fetch_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based behavioural model.
// Inputs change on the falling edge; outputs are sampled 1-2 time units after it.
module tb_fetch_seq;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, halt_req, stall, nop_en, imem_ack;
    logic [15:0] pc_bout, imem_rdata;
    logic [15:0] pc, imem_addr, instr, fetch_cnt;
    logic        imem_req, instr_valid, busy;
    logic [7:0]  squash_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_seq #(.DATA_W(16), .RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req), .stall(stall),
        .pc_bout(pc_bout), .nop_en(nop_en), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
        .instr_valid(instr_valid), .busy(busy), .squash_cnt(squash_cnt), .fetch_cnt(fetch_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Words waiting for decode live in a queue (front = presented word, second = parked word).
    // m_run: sequencer active; m_wait: a read is outstanding.
    logic [15:0] mq[$];
    logic        m_run, m_wait;
    logic [15:0] m_pc, m_fc;
    logic [7:0]  m_sq;

    function automatic logic exp_req();
        if (!m_run) return 1'b0;
        if (m_wait) return 1'b1;
        if (halt_req) return 1'b0;
        return (mq.size() == 0) || (mq.size() == 1 && !stall);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_run  = 1'b0;
            m_wait = 1'b0;
            m_pc   = RST_PC;
            m_fc   = 16'h0;
            m_sq   = 8'h0;
        end else begin
            logic r;
            r = exp_req();
            if (mq.size() > 0 && !stall) begin
                void'(mq.pop_front());
                m_fc = m_fc + 16'h1;
            end
            if (r && imem_ack) begin
                mq.push_back(nop_en ? NOP : imem_rdata);
                if (nop_en && m_sq != 8'hFF) m_sq = m_sq + 8'h1;
                m_pc = pc_bout;
            end
            if (!m_run) begin
                if (start && !halt_req) m_run = 1'b1;
            end else if (m_wait) begin
                if (imem_ack) begin
                    m_wait = 1'b0;
                    if (halt_req) m_run = 1'b0;
                end
            end else if (halt_req) begin
                m_run = 1'b0;
            end else if (r && !imem_ack) begin
                m_wait = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(negedge clk);
        #2;
        check("req", imem_req, exp_req());
        check("addr", imem_addr, m_pc);
        check("pc", pc, m_pc);
        check("busy", busy, m_run);
        check("valid", instr_valid, mq.size() > 0);
        if (mq.size() > 0) check("instr", instr, mq[0]);
        check("squash_cnt", squash_cnt, m_sq);
        check("fetch_cnt", fetch_cnt, m_fc);
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic st, input logic h, input logic s, input logic a,
                       input logic [15:0] d, input logic n, input logic [15:0] pb);
        start = st; halt_req = h; stall = s; imem_ack = a;
        imem_rdata = d; nop_en = n; pc_bout = pb;
        #1;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0);
        adv(); adv();
        check("rst_pc", pc, RST_PC);
        check("rst_req", imem_req, 1'b0);
        check("rst_instr", instr, NOP);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sq", squash_cnt, 8'h00);
        check("rst_fc", fetch_cnt, 16'h0000);
        reset_n = 1'b1;
        adv();
        check("idle_hold", busy, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0);
        do_reset();

        // Zero-wait fetch, rdata = addr.
        drv(1, 0, 0, 0, 16'h0, 0, 16'h0);    adv(); check("start_busy", busy, 1'b1);
        drv(0, 0, 0, 1, 16'h0000, 0, 16'h0001);
        check("zw_req", imem_req, 1'b1);     adv(); check("zw_i0", instr, 16'h0000);
        check("zw_v0", instr_valid, 1'b1);
        drv(0, 0, 0, 1, 16'h0001, 0, 16'h0002); adv(); check("zw_i1", instr, 16'h0001);
        drv(0, 0, 0, 1, 16'h0002, 0, 16'h0005); adv(); check("zw_i2", instr, 16'h0002);
        // Wait states at 0005, ack on the third requesting cycle.
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0);
        check("ws_req0", imem_req, 1'b1); check("ws_addr0", imem_addr, 16'h0005);
        adv(); check("zw_fc3", fetch_cnt, 16'd3); check("ws_v0", instr_valid, 1'b0);
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0);
        check("ws_req1", imem_req, 1'b1); check("ws_addr1", imem_addr, 16'h0005);
        adv(); check("ws_v1", instr_valid, 1'b0);
        drv(0, 0, 0, 1, 16'h0005, 0, 16'h0006);
        check("ws_req2", imem_req, 1'b1); check("ws_addr2", imem_addr, 16'h0005);
        adv(); check("ws_i", instr, 16'h0005);
        // Squash two captures, redirect to 0040.
        drv(0, 0, 0, 1, 16'h1234, 1, 16'h0040); adv();
        check("sq_i0", instr, NOP); check("sq_c1", squash_cnt, 8'd1);
        drv(0, 0, 0, 1, 16'h1234, 1, 16'h0040); adv();
        check("sq_i1", instr, NOP); check("sq_c2", squash_cnt, 8'd2);
        check("sq_addr", imem_addr, 16'h0040);
        // Stall while a WAIT ack arrives.
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0);    adv(); check("st_fc", fetch_cnt, 16'd6);
        drv(0, 0, 1, 1, 16'hABCD, 0, 16'h0041); adv(); check("st_i", instr, 16'hABCD);
        drv(0, 0, 1, 1, 16'h9999, 0, 16'h0077);
        check("st_noreq", imem_req, 1'b0);   adv(); check("st_hold", instr, 16'hABCD);
        check("st_pc", pc, 16'h0041);
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0);
        check("st_resume", imem_req, 1'b1);  adv(); check("st_fc2", fetch_cnt, 16'd7);
        // Halt while waiting at 0010.
        drv(0, 0, 0, 1, 16'h0041, 0, 16'h0010); adv();
        drv(0, 0, 0, 0, 16'h0, 0, 16'h0);    adv(); check("h_addr", imem_addr, 16'h0010);
        drv(0, 1, 0, 0, 16'h0, 0, 16'h0);
        check("h_wreq", imem_req, 1'b1);     adv(); check("h_wbusy", busy, 1'b1);
        drv(0, 1, 0, 1, 16'h7777, 0, 16'h0020); adv();
        check("h_i", instr, 16'h7777); check("h_busy", busy, 1'b0); check("h_pc", pc, 16'h0020);
        drv(0, 0, 0, 1, 16'h5555, 0, 16'h0099);
        check("h_noreq", imem_req, 1'b0);    adv(); check("h_pchold", pc, 16'h0020);
        drv(1, 0, 0, 0, 16'h0, 0, 16'h0);    adv(); check("r_busy", busy, 1'b1);
        drv(0, 0, 0, 1, 16'h0020, 0, 16'h0021);
        check("r_addr", imem_addr, 16'h0020); adv(); check("r_i", instr, 16'h0020);
        // Halt beats start.
        drv(0, 1, 0, 0, 16'h0, 0, 16'h0);    adv(); check("hs_0", busy, 1'b0);
        drv(1, 1, 0, 0, 16'h0, 0, 16'h0);    adv(); check("hs_1", busy, 1'b0);
        drv(1, 0, 0, 0, 16'h0, 0, 16'h0);    adv(); check("hs_2", busy, 1'b1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(3) == 0), ($urandom_range(9) == 0), ($urandom_range(2) == 0),
                ($urandom_range(1) == 0), 16'($urandom), ($urandom_range(7) == 0), 16'($urandom));
            if ($urandom_range(199) == 0) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            adv();
        end

        // Counter limits: 300 squashes then deliveries until fetch_cnt wraps.
        do_reset();
        drv(1, 0, 0, 0, 16'h0, 0, 16'h0); adv();
        for (int i = 0; i < 300; i++) begin
            drv(0, 0, 0, 1, 16'($urandom), 1, 16'(i + 1)); adv();
        end
        check("sq_sat", squash_cnt, 8'hFF);
        for (int i = 300; i < 65537; i++) begin
            drv(0, 0, 0, 1, 16'($urandom), 0, 16'(i + 1)); adv();
        end
        check("fc_wrap", fetch_cnt, 16'h0000);
        check("sq_sat2", squash_cnt, 8'hFF);

        drv(0, 1, 0, 0, 16'h0, 0, 16'h0);
        adv(); adv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameters: DATA_W, 16, instruction/address width; RESET_PC, 16'h0000, first fetch address; NOP_WORD, 16'h0000, word substituted for squashed instructions.
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  leave IDLE/HALT and begin fetching.
- halt_req  in  1  stop fetching after any in-flight access.
- stall  in  1  downstream cannot accept an instruction this cycle.
- pc_bout  in  DATA_W  next-PC from branch controller.
- nop_en  in  1  squash request from branch controller.
- imem_ack  in  1  instruction memory data valid this cycle.
- imem_rdata  in  DATA_W  instruction memory read data.
- pc  out  DATA_W  current fetch PC, drives branch controller pc_in.
- imem_req  out  1  memory read request.
- imem_addr  out  DATA_W  memory read address.
- instr  out  DATA_W  registered instruction to decode.
- instr_valid  out  1  instr is presented.
- busy  out  1  state is FETCH or WAIT.
- squash_cnt  out  8  squashed-instruction count.
- fetch_cnt  out  16  delivered-instruction count.

Function
REQ-003 SHALL implement states IDLE, FETCH, WAIT, HALT.
REQ-004 imem_req SHALL be 1 in WAIT, and 1 in FETCH when the output slot is free; 0 otherwise. imem_addr SHALL equal pc.
REQ-005 Output slot free SHALL mean instr_valid=0 or stall=0.
REQ-006 IDLE: start=1 -> FETCH next cycle with pc=RESET_PC. start=0 -> remain in IDLE.
REQ-007 FETCH, request issued, imem_ack=1 -> capture into instr, set instr_valid=1 next cycle, load pc<=pc_bout, remain FETCH.
REQ-008 FETCH, request issued, imem_ack=0 -> WAIT with pc held.
REQ-009 WAIT: remain until imem_ack=1, then capture per REQ-007 and go to FETCH.
REQ-010 WAIT: halt_req SHALL be ignored until ack; on ack with halt_req=1, capture the word, then go to HALT.
REQ-011 FETCH with halt_req=1 SHALL issue no request and go to HALT next cycle.
REQ-012 HALT: imem_req=0, pc held. start=1 -> FETCH resuming at held pc.
REQ-013 halt_req SHALL have priority over start when both are 1.
REQ-014 Capture with nop_en=1 SHALL load instr=NOP_WORD and instr_valid=1, and increment squash_cnt; pc still loads pc_bout.
REQ-015 squash_cnt SHALL saturate at 8'hFF.
REQ-016 When instr_valid=1 and stall=1, instr and instr_valid SHALL hold.
REQ-017 In WAIT with stall=1 and an occupied slot, an arriving ack SHALL be held in a one-entry skid buffer. The request SHALL drop after the ack. The skid word SHALL move to instr on the first stall=0 cycle, and fetching SHALL resume after that move.
REQ-018 With instr_valid=1, stall=0 and no new capture, instr_valid SHALL clear next cycle.
REQ-019 fetch_cnt SHALL increment once per cycle with instr_valid=1 and stall=0, including squashed words. It SHALL wrap FFFF->0000.
REQ-020 busy SHALL be a registered decode of state.
REQ-021 nop_en SHALL affect only the captured word; it SHALL never alter state, request or pc hold.

Reset
REQ-022 reset_n=0 SHALL force, asynchronously, state=IDLE, pc=RESET_PC, imem_req=0, instr=NOP_WORD, instr_valid=0, skid buffer empty, busy=0, squash_cnt=0, fetch_cnt=0.
REQ-023 Reset during WAIT SHALL drop imem_req immediately. The pending ack SHALL be discarded.
REQ-024 After reset release, the block SHALL stay in IDLE until start=1.

Verification
REQ-025 Zero-wait fetch: reset, start pulse, memory acks every cycle with rdata=addr, pc_bout=pc+1 -> instr 0000,0001,0002 on consecutive cycles; fetch_cnt=3 after 3 cycles.
REQ-026 Wait states: ack delayed 2 cycles at addr 0005 -> imem_req held 3 cycles, imem_addr=0005 stable, instr_valid=0 for 2 cycles, then instr=0005.
REQ-027 Squash: nop_en=1 for 2 captures, pc_bout=0040 -> two instr=0000 words, squash_cnt=2, next fetch address 0040.
REQ-028 Stall/skid: stall=1 while WAIT ack arrives with rdata=ABCD -> instr held, no new request; stall=0 -> next instr=ABCD, then fetching resumes.
REQ-029 Halt/resume: halt_req in WAIT at addr 0010 -> word captured, HALT, imem_req=0; start -> fetch at pc_bout value held.
REQ-030 Counters: force 300 squashes -> squash_cnt=FF; 65536 deliveries -> fetch_cnt=0000.
